// File: rtl/counter_modulo_down.sv
// Loadable modulo down-counter with terminal-count strobe, periodic or one-shot.
// Optional wrap counter output enabled by defining COUNTER_DOWN_WRAPCNT_EN.
module counter_modulo_down #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             counter_en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
`ifdef COUNTER_DOWN_WRAPCNT_EN
  ,
  output logic [7:0]       wrap_count
`endif
);

  localparam int unsigned WRAP_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] period_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             wrap;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      period <= '0;
      count  <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_nxt;
      period <= period_nxt;
      count  <= count_nxt;
      tc     <= tc_nxt;
    end
  end

  // Next-state: load restarts from any state and pre-empts a coincident wrap
  always_comb begin
    state_nxt  = state;
    period_nxt = period;
    count_nxt  = count;
    tc_nxt     = 1'b0;
    wrap       = 1'b0;
    if (load) begin
      period_nxt = data;
      count_nxt  = data;
      state_nxt  = RUN;
    end else begin
      case (state)
        RUN: begin
          if (counter_en) begin
            if (count != '0) begin
              count_nxt = count - WIDTH'(1);
            end else begin
              tc_nxt = 1'b1;
              wrap   = 1'b1;
              if (auto_reload) begin
                count_nxt = period;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);

`ifdef COUNTER_DOWN_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_count_nxt;

  // Saturating count of tc pulses, cleared on load
  always_comb begin
    wrap_count_nxt = wrap_count;
    if (load) begin
      wrap_count_nxt = '0;
    end else if (wrap && (wrap_count != {WRAP_W{1'b1}})) begin
      wrap_count_nxt = wrap_count + WRAP_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_count <= '0;
    end else begin
      wrap_count <= wrap_count_nxt;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap ^ (WRAP_W != 0);
`endif

endmodule

// File: tb/tb_counter_modulo_down.sv
// Self-checking bench for counter_modulo_down: directed scenarios plus
// randomized stimulus against a cycle-level behavioural model.
module tb_counter_modulo_down;

  localparam int unsigned WIDTH = 4;

  logic             clock       = 1'b0;
  logic             reset       = 1'b0;
  logic             counter_en  = 1'b0;
  logic             load        = 1'b0;
  logic [WIDTH-1:0] data        = '0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
`ifdef COUNTER_DOWN_WRAPCNT_EN
  logic [7:0]       wrap_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_period;
  int m_count;
  int m_wc;
  bit m_run;
  bit m_tc;

  counter_modulo_down #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .counter_en  (counter_en),
    .load        (load),
    .data        (data),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy)
`ifdef COUNTER_DOWN_WRAPCNT_EN
    ,
    .wrap_count  (wrap_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_period = 0;
    m_count  = 0;
    m_wc     = 0;
    m_run    = 1'b0;
    m_tc     = 1'b0;
  endfunction

  function automatic void model_step();
    m_tc = 1'b0;
    if (load) begin
      m_period = int'(data);
      m_count  = int'(data);
      m_run    = 1'b1;
      m_wc     = 0;
    end else if (m_run && counter_en) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_tc = 1'b1;
        if (m_wc < 255) m_wc = m_wc + 1;
        if (auto_reload) m_count = m_period;
        else m_run = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drive(input bit ld, input bit en, input int d, input bit ar);
    load        = ld;
    counter_en  = en;
    data        = WIDTH'(d);
    auto_reload = ar;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (count !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: count=%0d tc=%b busy=%b, want 0 0 0", count, tc, busy);
    end
    #10 reset = 1'b0;
    drive(1, 1, 5, 1);
    tick();
    drive(0, 0, 0, 1);
    tick();
    n_checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload: count=%0d busy=%b, want 5 1", count, busy);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (count !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d tc=%b busy=%b, want 0 0 0", count, tc, busy);
    end
    #2 reset = 1'b0;
    drive(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count !== '0 || tc !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: count=%0d tc=%b busy=%b, want 0 0 0", i, count, tc, busy);
      end
    end
  endtask

  task automatic test_one_shot();
    int exp_count [6] = '{3, 2, 1, 0, 0, 0};
    bit exp_tc    [6] = '{0, 0, 0, 0, 1, 0};
    bit exp_busy  [6] = '{1, 1, 1, 1, 0, 0};
    drive(1, 1, 3, 0);
    tick();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (count !== WIDTH'(exp_count[i]) || tc !== exp_tc[i] || busy !== exp_busy[i]) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: count=%0d tc=%b busy=%b, want %0d %b %b",
                 i, count, tc, busy, exp_count[i], exp_tc[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_periodic();
    int n_tc = 0;
    drive(1, 1, 2, 1);
    tick();
    drive(0, 1, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (tc === 1'b1) n_tc++;
      n_checks++;
      if (count !== WIDTH'(2 - (k % 3)) || tc !== ((k % 3) == 0)) begin
        n_fail++;
        $display("FAIL periodic[%0d]: count=%0d tc=%b, want %0d %b",
                 k, count, tc, 2 - (k % 3), (k % 3) == 0);
      end
    end
    n_checks++;
    if (n_tc != 3) begin
      n_fail++;
      $display("FAIL periodic_tc_count: got %0d pulses, want 3", n_tc);
    end
  endtask

  task automatic test_enable_gaps();
    int last_tc = -1;
    bit en_edge;
    drive(1, 1, 4, 1);
    tick();
    for (int i = 0; i < 40; i++) begin
      en_edge = (i % 2) == 0;
      drive(0, en_edge, 0, 1);
      tick();
      n_checks++;
      if (count !== WIDTH'(m_count) || tc !== m_tc || (tc === 1'b1 && !en_edge)) begin
        n_fail++;
        $display("FAIL gaps[%0d]: count=%0d tc=%b en=%b, want %0d %b", i, count, tc, en_edge, m_count, m_tc);
      end
      if (tc === 1'b1) begin
        if (last_tc >= 0) begin
          n_checks++;
          if (i - last_tc != 10) begin
            n_fail++;
            $display("FAIL gaps_interval: got %0d clocks, want 10", i - last_tc);
          end
        end
        last_tc = i;
      end
    end
    n_checks++;
    if (last_tc < 0) begin
      n_fail++;
      $display("FAIL gaps_no_tc: got no tc pulse, want pulses every 10 clocks");
    end
  endtask

  task automatic test_load_collision();
    drive(1, 1, 2, 1);
    tick();
    drive(0, 1, 0, 1);
    tick();
    tick();
    n_checks++;
    if (count !== '0) begin
      n_fail++;
      $display("FAIL collide_pre: count=%0d, want 0", count);
    end
    drive(1, 1, 7, 1);
    tick();
    n_checks++;
    if (count !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_load: count=%0d tc=%b busy=%b, want 7 0 1", count, tc, busy);
    end
    drive(1, 1, 0, 1);
    tick();
    drive(0, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (count !== '0 || tc !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL period0[%0d]: count=%0d tc=%b busy=%b, want 0 1 1", i, count, tc, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 8) == 0, ($urandom % 4) != 0, int'($urandom % 16), ($urandom % 3) != 0);
      tick();
      n_checks++;
      if (count !== WIDTH'(m_count) || tc !== m_tc || busy !== m_run) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d tc=%b busy=%b, want %0d %b %b",
                 i, count, tc, busy, m_count, m_tc, m_run);
      end
`ifdef COUNTER_DOWN_WRAPCNT_EN
      n_checks++;
      if (wrap_count !== 8'(m_wc)) begin
        n_fail++;
        $display("FAIL random_wc[%0d]: wrap_count=%0d, want %0d", i, wrap_count, m_wc);
      end
`endif
    end
  endtask

`ifdef COUNTER_DOWN_WRAPCNT_EN
  task automatic test_wrapcnt();
    drive(1, 1, 0, 1);
    tick();
    drive(0, 1, 0, 1);
    for (int i = 0; i < 300; i++) tick();
    n_checks++;
    if (wrap_count !== 8'd255) begin
      n_fail++;
      $display("FAIL wrapcnt_sat: wrap_count=%0d, want 255", wrap_count);
    end
    drive(1, 1, 5, 1);
    tick();
    n_checks++;
    if (wrap_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrapcnt_clear: wrap_count=%0d, want 0", wrap_count);
    end
    drive(0, 0, 0, 1);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_gaps();
    test_load_collision();
    test_random();
`ifdef COUNTER_DOWN_WRAPCNT_EN
    test_wrapcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
